// File: rtl/demux1x4_if.sv
// Purpose: bundles the producer stream, the four channel outputs and their accepts for demux1x4.
// Latency: none, this is wiring only.
// Backpressure: i_ready flows to the producer, r0..r3 flow from the four consumers.
interface demux1x4_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] i;
    logic             i_valid;
    logic             i_ready;
    logic             sel1;
    logic             sel0;

    logic [WIDTH-1:0] f0, f1, f2, f3;
    logic             v0, v1, v2, v3;
    logic             r0, r1, r2, r3;
    logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;

    // Producer / consumer side (testbench or surrounding logic).
    modport master (
        output i, i_valid, sel1, sel0, r0, r1, r2, r3,
        input  i_ready, f0, f1, f2, f3, v0, v1, v2, v3, cnt0, cnt1, cnt2, cnt3
    );

    // Demux side.
    modport slave (
        input  i, i_valid, sel1, sel0, r0, r1, r2, r3,
        output i_ready, f0, f1, f2, f3, v0, v1, v2, v3, cnt0, cnt1, cnt2, cnt3
    );
endinterface

// File: rtl/demux1x4.sv
// Purpose: registered 1-to-4 stream demux, one holding register and delivered-beat counter per channel.
// Latency: one cycle from input handshake to the beat appearing on fn/vn.
// Backpressure: i_ready drops only when the addressed channel is full and its consumer is stalled.
module demux1x4 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    demux1x4_if.slave  bus
);

    // Channel index: sel0 is the MSB.
    logic [1:0]       sel;
    logic [3:0]       rdy_vec;

    logic [3:0]       v_q;
    logic [WIDTH-1:0] f_q   [4];
    logic [CNT_W-1:0] cnt_q [4];

    logic             i_ready_c;
    logic             in_hs;
    logic [3:0]       out_hs;
    logic [3:0]       load;

    assign sel     = {bus.sel0, bus.sel1};
    assign rdy_vec = {bus.r3, bus.r2, bus.r1, bus.r0};

    // Accept when the addressed channel is empty or is being drained this cycle.
    always_comb begin
        i_ready_c = 1'b0;
        if (!rst) begin
            i_ready_c = !v_q[sel] || rdy_vec[sel];
        end
    end

    assign in_hs  = bus.i_valid && i_ready_c;
    // A consumer's accept only matters while its channel holds a beat.
    assign out_hs = v_q & rdy_vec;

    // One-hot load strobe for the channel receiving the accepted beat.
    always_comb begin
        load = 4'b0000;
        if (in_hs) begin
            load[sel] = 1'b1;
        end
    end

    // Per-channel holding register, valid flag and wrapping delivered-beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                f_q[k]   <= '0;
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    // A reload while draining keeps the channel full.
                    f_q[k] <= bus.i;
                    v_q[k] <= 1'b1;
                end else if (out_hs[k]) begin
                    // Data is left in place; only the valid flag drops.
                    v_q[k] <= 1'b0;
                end
                if (out_hs[k]) begin
                    cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                end
            end
        end
    end

    assign bus.i_ready = i_ready_c;

    assign bus.f0 = f_q[0];
    assign bus.f1 = f_q[1];
    assign bus.f2 = f_q[2];
    assign bus.f3 = f_q[3];

    assign bus.v0 = v_q[0];
    assign bus.v1 = v_q[1];
    assign bus.v2 = v_q[2];
    assign bus.v3 = v_q[3];

    assign bus.cnt0 = cnt_q[0];
    assign bus.cnt1 = cnt_q[1];
    assign bus.cnt2 = cnt_q[2];
    assign bus.cnt3 = cnt_q[3];

endmodule

// File: tb/tb_demux1x4.sv
// Purpose: self-checking bench for demux1x4 using a per-channel scoreboard and a 4-to-1 mux model.
// Latency: checks that beats appear one cycle after acceptance.
// Backpressure: exercises stalled and free channels, reset while full, and counter wrap.
module tb_demux1x4;

    localparam int W  = 1;
    localparam int CW = 8;

    logic clk;
    logic rst;

    demux1x4_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    demux1x4 #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Scoreboard: beats expected to be held per channel, and expected delivered counts.
    logic [W-1:0]  q       [4][$];
    logic [CW-1:0] cnt_exp [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] get_f(input int k);
        case (k)
            0:       return 32'(bus.f0);
            1:       return 32'(bus.f1);
            2:       return 32'(bus.f2);
            default: return 32'(bus.f3);
        endcase
    endfunction

    function automatic logic get_v(input int k);
        case (k)
            0:       return bus.v0;
            1:       return bus.v1;
            2:       return bus.v2;
            default: return bus.v3;
        endcase
    endfunction

    function automatic logic get_r(input int k);
        case (k)
            0:       return bus.r0;
            1:       return bus.r1;
            2:       return bus.r2;
            default: return bus.r3;
        endcase
    endfunction

    function automatic logic [31:0] get_cnt(input int k);
        case (k)
            0:       return 32'(bus.cnt0);
            1:       return 32'(bus.cnt1);
            2:       return 32'(bus.cnt2);
            default: return 32'(bus.cnt3);
        endcase
    endfunction

    // Gate-level 4-to-1 mux with the same select encoding (sel0 = MSB).
    function automatic logic [31:0] mux4(input logic [1:0] n);
        logic [W-1:0] s0, s1, o;
        s0 = {W{n[1]}};
        s1 = {W{n[0]}};
        o  = (~s0 & ~s1 & bus.f0) | (~s0 & s1 & bus.f1) |
             ( s0 & ~s1 & bus.f2) | ( s0 & s1 & bus.f3);
        return 32'(o);
    endfunction

    task automatic cyc(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    task automatic set_r(input logic [3:0] r);
        bus.r0 = r[0];
        bus.r1 = r[1];
        bus.r2 = r[2];
        bus.r3 = r[3];
    endtask

    task automatic set_sel(input logic [1:0] n);
        bus.sel0 = n[1];
        bus.sel1 = n[0];
    endtask

    // Drive one beat and hold it until accepted (bounded wait).
    task automatic send(input logic [1:0] n, input logic [W-1:0] d);
        int t;
        t = 0;
        set_sel(n);
        bus.i       = d;
        bus.i_valid = 1'b1;
        @(negedge clk);
        while (!bus.i_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.i_ready) chk("send_timeout", 32'(bus.i_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
    endtask

    // Monitor: at each falling edge, compare held state with the scoreboard and
    // apply the handshakes that the coming rising edge will perform.
    logic [1:0] mon_n;
    logic       mon_rdy;
    always @(negedge clk) begin
        mon_n = {bus.sel0, bus.sel1};
        if (rst) begin
            chk("rst_ready", 32'(bus.i_ready), 32'd0);
            for (int k = 0; k < 4; k++) begin
                q[k].delete();
                cnt_exp[k] = '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                chk("v_occ", 32'(get_v(k)), 32'(q[k].size() != 0));
                if (q[k].size() != 0) chk("f_hold", get_f(k), 32'(q[k][0]));
                chk("cnt", get_cnt(k), 32'(cnt_exp[k]));
            end
            mon_rdy = (q[mon_n].size() == 0) || get_r(int'(mon_n));
            chk("i_ready", 32'(bus.i_ready), 32'(mon_rdy));
            for (int k = 0; k < 4; k++) begin
                if (q[k].size() != 0 && get_r(k)) begin
                    void'(q[k].pop_front());
                    cnt_exp[k] = cnt_exp[k] + CW'(1);
                end
            end
            if (bus.i_valid && mon_rdy) q[mon_n].push_back(bus.i);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    logic [5:0] pat;

    initial begin
        rst         = 1'b1;
        bus.i       = '0;
        bus.i_valid = 1'b0;
        set_sel(2'b00);
        set_r(4'b0000);
        for (int k = 0; k < 4; k++) cnt_exp[k] = '0;

        // Reset state.
        cyc(2);
        @(negedge clk);
        chk("rst_hold_ready", 32'(bus.i_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("rst_v", 32'(get_v(k)), 32'd0);
            chk("rst_f", get_f(k), 32'd0);
            chk("rst_cnt", get_cnt(k), 32'd0);
        end
        chk("post_rst_ready", 32'(bus.i_ready), 32'd1);
        @(posedge clk); #1;

        // One beat of 1 on each channel, all consumers ready.
        set_r(4'b1111);
        for (int k = 0; k < 4; k++) begin
            send(2'(k), 1'b1);
            @(negedge clk);
            chk("lat_f", get_f(k), 32'd1);
            chk("lat_v", 32'(get_v(k)), 32'd1);
            @(posedge clk); #1;
        end
        cyc(1);
        @(negedge clk);
        for (int k = 0; k < 4; k++) chk("one_each_cnt", get_cnt(k), 32'd1);
        @(posedge clk); #1;

        // Stalled channel 2 blocks only beats addressed to it.
        do_reset();
        set_r(4'b1011);
        send(2'b10, 1'b1);
        cyc(2);
        @(negedge clk);
        chk("stall_v2", 32'(bus.v2), 32'd1);
        chk("stall_f2", 32'(bus.f2), 32'd1);
        @(posedge clk); #1;
        set_sel(2'b10);
        bus.i       = 1'b0;
        bus.i_valid = 1'b1;
        @(negedge clk);
        chk("stall_ready", 32'(bus.i_ready), 32'd0);
        @(posedge clk); #1;
        set_sel(2'b00);
        bus.i = 1'b1;
        @(negedge clk);
        chk("free_ready", 32'(bus.i_ready), 32'd1);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        @(negedge clk);
        chk("free_f0", 32'(bus.f0), 32'd1);
        chk("free_v0", 32'(bus.v0), 32'd1);
        chk("still_f2", 32'(bus.f2), 32'd1);
        @(posedge clk); #1;
        set_r(4'b1111);
        @(posedge clk); #1;
        @(negedge clk);
        chk("drain_v2", 32'(bus.v2), 32'd0);
        chk("drain_cnt2", 32'(bus.cnt2), 32'd1);
        chk("drain_cnt0", 32'(bus.cnt0), 32'd1);
        @(posedge clk); #1;

        // Back-to-back stream on channel 1.
        do_reset();
        pat = 6'b101101;
        for (int j = 0; j < 6; j++) begin
            set_sel(2'b01);
            bus.i       = pat[j];
            bus.i_valid = 1'b1;
            @(negedge clk);
            chk("strm_ready", 32'(bus.i_ready), 32'd1);
            if (j > 0) begin
                chk("strm_f1", 32'(bus.f1), 32'(pat[j-1]));
                chk("strm_v1", 32'(bus.v1), 32'd1);
            end
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
        @(negedge clk);
        chk("strm_last_f1", 32'(bus.f1), 32'(pat[5]));
        chk("strm_last_v1", 32'(bus.v1), 32'd1);
        @(posedge clk); #1;
        cyc(1);
        @(negedge clk);
        chk("strm_cnt1", 32'(bus.cnt1), 32'd6);
        @(posedge clk); #1;

        // 256 beats on channel 3 wrap its counter; others untouched.
        for (int j = 0; j < 256; j++) begin
            set_sel(2'b11);
            bus.i       = W'(j & 1);
            bus.i_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
        cyc(2);
        @(negedge clk);
        chk("wrap_cnt3", 32'(bus.cnt3), 32'd0);
        chk("wrap_cnt1", 32'(bus.cnt1), 32'd6);
        chk("wrap_cnt0", 32'(bus.cnt0), 32'd0);
        chk("wrap_cnt2", 32'(bus.cnt2), 32'd0);
        @(posedge clk); #1;

        // Reset while all four channels are full and r0 is high.
        set_r(4'b0000);
        for (int k = 0; k < 4; k++) send(2'(k), 1'b1);
        rst = 1'b1;
        set_r(4'b0001);
        @(negedge clk);
        chk("mid_rst_ready", 32'(bus.i_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("mid_rst_v", 32'(get_v(k)), 32'd0);
            chk("mid_rst_f", get_f(k), 32'd0);
            chk("mid_rst_cnt", get_cnt(k), 32'd0);
        end
        chk("mid_rst_after_ready", 32'(bus.i_ready), 32'd1);
        @(posedge clk); #1;

        // Round trip through the 4-to-1 mux: background b on all channels, then d on channel n.
        for (int b = 0; b < 2; b++) begin
            for (int d = 0; d < 2; d++) begin
                for (int n = 0; n < 4; n++) begin
                    set_r(4'b1111);
                    cyc(1);
                    set_r(4'b0000);
                    for (int k = 0; k < 4; k++) send(2'(k), W'(b));
                    set_r(4'b0001 << n);
                    send(2'(n), W'(d));
                    set_r(4'b0000);
                    @(negedge clk);
                    chk("rt_sel", mux4(2'(n)), 32'(d));
                    chk("rt_other", mux4(2'(n ^ 1)), 32'(b));
                    @(posedge clk); #1;
                end
            end
        end
        set_r(4'b1111);
        cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux1x4.md
# demux1x4

Registered 1-to-4 demultiplexer that steers a single valid/ready input stream to one of four output channels chosen per beat by a 2-bit select. It is the distribution counterpart of the 4-to-1 gate-level mux: a value pushed through `demux1x4` on channel n and read back through the mux with the same select returns the original value. Each output channel has a one-entry holding register and a delivered-beat counter, so the block can sit between a single producer and four independently stalling consumers.

## Interface
- `WIDTH`, default 1: data width of the input and of each output channel.
- `CNT_W`, default 8: width of each per-channel delivered-beat counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i`  in  WIDTH  input data beat.
- `i_valid`  in  1  producer asserts while `i` and select are valid.
- `i_ready`  out  1  block can accept the current beat.
- `sel1`, `sel0`  in  1 each  channel select, sampled with the beat; channel index n = {sel0, sel1}, so sel0 is the MSB (00→f0, 01→f1, 10→f2, 11→f3).
- `f0`..`f3`  out  WIDTH each  channel output data.
- `v0`..`v3`  out  1 each  channel holds a valid beat.
- `r0`..`r3`  in  1 each  consumer of that channel accepts.
- `cnt0`..`cnt3`  out  CNT_W each  beats delivered on that channel (output handshakes), wrapping.

## Operation
- Input handshake is `i_valid && i_ready`. Output handshake on channel n is `vn && rn`.
- `i_ready` is combinational: `!rst && (!v_sel || r_sel)`, where `sel` is the channel addressed by the current {sel0, sel1}. It depends on the current select, so a producer that changes select may see `i_ready` change in the same cycle.
- On an input handshake to channel n:
  - `fn` loads `i`.
  - `vn` is set to 1.
- On an output handshake on channel n with no input handshake to n in that cycle:
  - `vn` clears to 0.
  - `fn` holds its last value.
- When an input handshake to channel n and an output handshake on n occur in the same cycle:
  - `fn` reloads with the new beat.
  - `vn` stays 1.
  - `cntn` increments.
- Channels are independent. An input handshake to channel n and drains on any other channels in the same cycle all take effect.
- A stalled channel blocks only beats addressed to that channel. Beats addressed to free channels are accepted normally.
- Stability: while `vn` is 1 and `rn` is 0, `fn` does not change.
- Counter `cntn` increments by 1 on each output handshake on channel n. It wraps from 2^CNT_W−1 to 0 and does not saturate.
- No beat is duplicated, dropped, or reordered within a channel.

## Timing
- Reset: while `rst` is 1 at a rising edge, all `vn` = 0, all `fn` = 0 and all `cntn` = 0 after that edge. `i_ready` = 0 for as long as `rst` is high.
- Reset mid-operation: held beats are discarded and counters are cleared. No output handshake is counted in the reset cycle.
- Latency: a beat accepted at edge k appears on `fn`/`vn` after edge k; one cycle.
- Throughput: 1 beat per cycle to any single channel while its consumer holds `rn` = 1. Beats may alternate between channels every cycle.
- `rn` is ignored while `vn` = 0: no state change and no count.
- `i` and select are ignored when `i_valid` = 0 or `i_ready` = 0.

## Test plan
- Reset, then send one beat of 1 on each select 00, 01, 10, 11 with all `rn` = 1. Required: the 1 appears on f0, f1, f2, f3 respectively, each one cycle after acceptance, and every `cntn` ends at 1.
- Hold `r2` = 0 and send a beat with value 1 on select 10. Required: `v2` = 1 and `f2` = 1 stay stable, and `i_ready` = 0 while select = 10. With select = 00, `i_ready` = 1 and the beat lands on f0. Then raise `r2`. Required: `v2` drops the next cycle and `cnt2` = 1.
- Stream 6 back-to-back beats (1,0,1,1,0,1) on select 01 with `r1` = 1. Required: `i_ready` stays 1 throughout, f1 shows the same sequence one cycle late with `v1` continuously high, and `cnt1` = 6.
- Send 256 beats on select 11 with `CNT_W` = 8. Required: `cnt3` wraps to 0 and other counters are unchanged.
- Assert `rst` while all four channels hold beats and `r0` = 1. Required: after the edge, all `vn` = 0, all `fn` = 0 and all `cntn` = 0. `i_ready` = 0 during reset and 1 in the first cycle after reset.
- Round-trip: feed `f0`..`f3` into the 4-to-1 mux with the same `sel1`/`sel0` for each beat. Required: the mux output equals the demux input for all 16 combinations of data pattern and select.
